// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl - run/halt/single-step controller for the CPU clock.
// Divides clk_in by a runtime-loadable divisor into a square clk_out plus a
// one-cycle clk_en strobe per CPU period. Halting and stepping only happen on
// whole-period boundaries, so the CPU never sees a truncated phase.
// Optional feature macro: CPU_CLOCK_CYCLE_COUNT_EN adds a 32-bit cycle_count
// output that counts clk_en strobes.
module cpu_clock_ctrl #(
  parameter int unsigned DIVISOR = 32'd10_000_000,
  parameter int          DIV_W   = 28
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_data,
  output logic             div_busy,
  output logic             clk_out,
  output logic             clk_en,
  output logic             halted
`ifdef CPU_CLOCK_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  localparam logic [1:0]       MODE_RUN  = 2'b01;
  localparam logic [1:0]       MODE_STEP = 2'b10;
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RESET = (DIVISOR < 2) ? DIV_MIN : DIV_W'(DIVISOR);

  typedef enum logic [1:0] {
    S_HALTED   = 2'd0,
    S_RUNNING  = 2'd1,
    S_STEPPING = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] pend_q;
  logic [DIV_W-1:0] pend_d;
  logic             pend_vld_q;
  logic             pend_vld_d;
  logic             step_prev_q;
  logic             clk_out_d;
  logic             clk_en_d;

  logic             active;
  logic             step_rise;
  logic             at_boundary;
  logic [DIV_W-1:0] wr_val;

  // Shared decode: active period, step edge, last cycle of a period, clamped write value.
  assign active      = (state_q != S_HALTED);
  assign step_rise   = step_req & ~step_prev_q;
  assign at_boundary = active && (cnt_q == (div_q - DIV_W'(1)));
  assign wr_val      = (div_data < DIV_MIN) ? DIV_MIN : div_data;

  assign div_busy = pend_vld_q;
  assign halted   = (state_q == S_HALTED);

  // State register plus period counter, divisor and step-edge history.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALTED;
      cnt_q       <= '0;
      div_q       <= DIV_RESET;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      step_prev_q <= step_req;
    end
  end

  // Next state: leave HALTED on RUN or a STEP edge; return only at a period boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED: begin
        if (mode == MODE_RUN) begin
          state_d = S_RUNNING;
        end else if ((mode == MODE_STEP) && step_rise) begin
          state_d = S_STEPPING;
        end
      end
      S_RUNNING: begin
        if (at_boundary && (mode != MODE_RUN)) begin
          state_d = S_HALTED;
        end
      end
      S_STEPPING: begin
        if (at_boundary) begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // Period counter: held at zero while halted, wraps to zero at each boundary.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!active || at_boundary) begin
      cnt_d = '0;
    end
  end

  // Divisor update: immediate while halted, otherwise parked until the next boundary.
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (!active) begin
      if (div_wr) begin
        div_d      = wr_val;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (div_wr) begin
      pend_d     = wr_val;
      pend_vld_d = 1'b1;
    end else if (at_boundary && pend_vld_q) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // Output decode from the upcoming count so clk_out/clk_en can be registered.
  always_comb begin
    clk_out_d = (state_d != S_HALTED) && (cnt_d < (div_d >> 1));
    clk_en_d  = (state_d != S_HALTED) && (cnt_d == '0);
  end

  // Registered clock outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      clk_out <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      clk_out <= clk_out_d;
      clk_en  <= clk_en_d;
    end
  end

`ifdef CPU_CLOCK_CYCLE_COUNT_EN
  // Free-running count of CPU cycles, one per clk_en strobe, wrapping at 2^32.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (clk_en) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  // No cycle counter in this build.
`endif

endmodule
